sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO with registered read data, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It generalises our addressed RAM with full/empty tracking into a pointer-managed buffer with correct simultaneous read/write handling and a synchronous flush. It sits between a producer and a consumer in the same clock domain as the standard rate-matching buffer.

---
 rtl/sync_fifo_flags.sv | 85 ++++++++
 tb/tb_sync_fifo_flags.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, occupancy count, almost-full/
// almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_ok, rd_ok;

  // A read at full frees the slot the concurrent write lands in.
  always_comb begin
    wr_ok = wr_en & (~full | rd_en);
    rd_ok = rd_en & ~empty;
  end

  always_comb begin
    full         = (count == FULL_LVL);
    empty        = (count == '0);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
  end

  always_ff @(posedge clk) begin
    if (!clr && wr_ok)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok)
        count <= count + 1'b1;
      else if (rd_ok && !wr_ok)
        count <= count - 1'b1;
      if (wr_en && !wr_ok)
        overflow <= 1'b1;
      if (rd_en && !rd_ok)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a queue model of contents predicts
// accepts, count and flags; expected read words are queued and popped per read.
module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AFM   = 4;
  localparam int AEM   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq[$];     // model contents
  logic [WIDTH-1:0] exp_q[$];  // expected read results
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf  = 1'b0;
  logic             m_unf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = mq.size();
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_full"},  32'(full),  32'(n == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(n == 0));
    check({tag, "_af"},    32'(almost_full),  32'(n >= DEPTH - AFM));
    check({tag, "_ae"},    32'(almost_empty), 32'(n <= AEM));
    check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, "_unf"},   32'(underflow), 32'(m_unf));
  endtask

  // One clock: drive inputs, predict, clock, then compare #1 after the edge.
  task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic wok, rok;
    wr_en = w; din = d; rd_en = r; clr = 1'b0;
    rok = r && (mq.size() != 0);
    wok = w && ((mq.size() != DEPTH) || r);
    if (rok) exp_q.push_back(mq.pop_front());
    if (wok) mq.push_back(d);
    if (w && !wok) m_ovf = 1'b1;
    if (r && !rok) m_unf = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (rok) m_dout = exp_q.pop_front();
    check({tag, "_dout"}, 32'(dout), 32'(m_dout));
    check_flags(tag);
  endtask

  task automatic flush(input logic w, input logic [WIDTH-1:0] d);
    clr = 1'b1; wr_en = w; din = d; rd_en = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; wr_en = 1'b0;
    check("clr_dout", 32'(dout), 32'(m_dout));
    check_flags("clr");
  endtask

  initial begin
    // power-on reset
    #2;
    check("por_dout", 32'(dout), 0);
    check_flags("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // reset mid-transfer, no clock edge needed
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, WIDTH'(8'h30 + i), 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1);
    rst = 1'b1;
    mq.delete(); m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    check("rst_dout", 32'(dout), 0);
    check_flags("rst");
    rst = 1'b0;

    // flush with a concurrent write, clearing sticky underflow
    step("unf_set", 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, WIDTH'(8'h40 + i), 1'b0);
    step("pre_clr_rd", 1'b0, '0, 1'b1);
    flush(1'b1, 8'hEE);

    // fill, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, WIDTH'(i), 1'b0);
    step("ovf", 1'b1, 8'hBB, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("unf", 1'b0, '0, 1'b1);

    // empty + both: write accepted, read rejected
    step("empty_both", 1'b1, 8'h55, 1'b1);
    step("empty_both_rd", 1'b0, '0, 1'b1);
    flush(1'b0, '0);

    // full + both: head out, new word in, no overflow
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, WIDTH'(8'h80 + i), 1'b0);
    step("full_both", 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1);
    check("aa_last", 32'(dout), 32'h0000_00AA);

    // streaming across pointer wraps
    for (int i = 0; i < 10; i++) step("preload", 1'b1, WIDTH'(i), 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, WIDTH'(10 + i), 1'b1);
    for (int i = 0; i < 10; i++) step("stream_drain", 1'b0, '0, 1'b1);

    // random mix
    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
